// File: rtl/ethernet_tx_arbiter.sv
// rtl/ethernet_tx_arbiter.sv - round-robin arbiter sharing one MAC tx bus among NUM_PORTS frame sources
// Optional grant watchdog: define TX_ARB_WATCHDOG_EN.
module ethernet_tx_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int WATCHDOG_CYCLES = 4096,
    parameter int DATA_W          = 32,
    parameter int BV_W            = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_PORTS-1:0]               i_src_req,
    output logic [NUM_PORTS-1:0]               o_src_grant,
    input  logic [NUM_PORTS-1:0]               i_src_done,
    input  logic [NUM_PORTS-1:0]               i_src_start,
    input  logic [NUM_PORTS-1:0]               i_src_data_valid,
    input  logic [NUM_PORTS-1:0][BV_W-1:0]     i_src_bytes_valid,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   i_src_data,
    input  logic                               i_tx_ready,
    output logic                               o_tx_start,
    output logic                               o_tx_data_valid,
    output logic [BV_W-1:0]                    o_tx_bytes_valid,
    output logic [DATA_W-1:0]                  o_tx_data,
    output logic [31:0]                        o_frame_count,
    output logic                               o_watchdog_fault
);
    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

    state_t               r_state, w_state_next;
    logic [NUM_PORTS-1:0] r_grant;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     r_ptr;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_tx_start, r_tx_dv;
    logic [BV_W-1:0]      r_tx_bv;
    logic [DATA_W-1:0]    r_tx_data;
    logic [31:0]          r_frame_count;
    logic                 w_found;
    logic [SEL_W-1:0]     w_pick;
    logic [SEL_W-1:0]     w_idx;
    logic                 w_done;
    logic                 w_expire;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = SEL_W'((int'(r_ptr) + i) % NUM_PORTS);
            if (!w_found && i_src_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_done = i_src_done[r_sel];

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_fault;

    // src_done on the expiry cycle is a normal completion, not a fault.
    assign w_expire = (r_state == S_ACTIVE) && !w_done &&
                      (r_wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt   <= '0;
            r_wd_fault <= 1'b0;
        end else begin
            r_wd_fault <= w_expire;
            if (r_state != S_ACTIVE)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign o_watchdog_fault = r_wd_fault;
`else
    logic w_unused_wd;
    assign w_unused_wd      = (WATCHDOG_CYCLES == 0);
    assign w_expire         = 1'b0;
    assign o_watchdog_fault = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_tx_ready && w_found) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_done || w_expire) w_state_next = S_GAP;
            S_GAP:    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_sel         <= '0;
            r_ptr         <= '0;
            r_gap_cnt     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_dv       <= 1'b0;
            r_tx_bv       <= '0;
            r_tx_data     <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_ACTIVE: begin
                    r_tx_start <= i_src_start[r_sel];
                    r_tx_dv    <= i_src_data_valid[r_sel];
                    r_tx_bv    <= i_src_bytes_valid[r_sel];
                    r_tx_data  <= i_src_data[r_sel];
                    if (w_done || w_expire) begin
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                    end
                    if (w_done)
                        r_frame_count <= r_frame_count + 32'd1;
                end
                S_GAP: begin
                    r_tx_start <= 1'b0;
                    r_tx_dv    <= 1'b0;
                    r_tx_bv    <= '0;
                    r_gap_cnt  <= r_gap_cnt + 1'b1;
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_tx_dv    <= 1'b0;
                    r_tx_bv    <= '0;
                    if (i_tx_ready && w_found) begin
                        r_grant <= NUM_PORTS'(1) << w_pick;
                        r_sel   <= w_pick;
                        r_ptr   <= (w_pick == SEL_W'(NUM_PORTS - 1)) ? '0 : w_pick + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_src_grant      = r_grant;
    assign o_tx_start       = r_tx_start;
    assign o_tx_data_valid  = r_tx_dv;
    assign o_tx_bytes_valid = r_tx_bv;
    assign o_tx_data        = r_tx_data;
    assign o_frame_count    = r_frame_count;
endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// tb/tb_ethernet_tx_arbiter.sv - directed self-checking bench for ethernet_tx_arbiter
module tb_ethernet_tx_arbiter;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       src_req = '0;
    logic [3:0]       src_grant;
    logic [3:0]       src_done = '0;
    logic [3:0]       src_start = '0;
    logic [3:0]       src_dv = '0;
    logic [3:0][2:0]  src_bv = '0;
    logic [3:0][31:0] src_data = '0;
    logic             tx_ready = 1'b0;
    logic             tx_start, tx_dv;
    logic [2:0]       tx_bv;
    logic [31:0]      tx_data;
    logic [31:0]      frame_count;
    logic             wd_fault;

    int n_chk  = 0;
    int n_pass = 0;

    ethernet_tx_arbiter #(.NUM_PORTS(4), .GAP_CYCLES(2), .WATCHDOG_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_src_req(src_req), .o_src_grant(src_grant),
        .i_src_done(src_done), .i_src_start(src_start), .i_src_data_valid(src_dv),
        .i_src_bytes_valid(src_bv), .i_src_data(src_data), .i_tx_ready(tx_ready),
        .o_tx_start(tx_start), .o_tx_data_valid(tx_dv), .o_tx_bytes_valid(tx_bv),
        .o_tx_data(tx_data), .o_frame_count(frame_count), .o_watchdog_fault(wd_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_bus();
        src_done = '0; src_start = '0; src_dv = '0; src_bv = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; src_req = '0; clear_bus();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic beat(input int p, input logic st, input logic dv, input logic [2:0] bv,
                        input logic [31:0] d, input logic dn);
        src_start[p] = st; src_dv[p] = dv; src_bv[p] = bv; src_data[p] = d; src_done[p] = dn;
    endtask

    initial begin
        int w;
        logic bad;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("rst_grant", src_grant, 0);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", frame_count, 0);
        check("rst_fault", wd_fault, 0);

        // Single port 1 frame: start + 3 beats (4,4,2)
        src_req = 4'b0010; tx_ready = 1'b1;
        step();
        check("t1_grant", src_grant, 4'b0010);
        beat(1, 1, 1, 4, 32'hA1, 0);
        step();
        check("t1_b1", {tx_start, tx_dv, tx_bv, tx_data}, {1'b1, 1'b1, 3'd4, 32'hA1});
        beat(1, 0, 1, 4, 32'hA2, 0);
        step();
        check("t1_b2", {tx_start, tx_dv, tx_bv, tx_data}, {1'b0, 1'b1, 3'd4, 32'hA2});
        beat(1, 0, 1, 2, 32'hA3, 1);
        step();
        src_req = '0; clear_bus();
        check("t1_b3", {tx_start, tx_dv, tx_bv, tx_data}, {1'b0, 1'b1, 3'd2, 32'hA3});
        check("t1_drop", src_grant, 0);
        check("t1_count", frame_count, 1);
        step();
        check("t1_gap_bus", {tx_dv, tx_bv, tx_data}, {1'b0, 3'd0, 32'hA3});

        // Fairness: all requesting, one-beat frames
        do_reset();
        src_req = 4'b1111; tx_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (src_grant == 0 && w < 10) begin
                step();
                w++;
            end
            if (k > 0) check("t2_gap_len", w, 3);
            check("t2_order", src_grant, 4'b0001 << order[k]);
            beat(order[k], 1, 1, 4, 32'hB0 + k, 1);
            step();
            clear_bus();
        end
        check("t2_count", frame_count, 5);

        // tx_ready held low
        do_reset();
        src_req = 4'b0001; tx_ready = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (src_grant != 0) bad = 1'b1;
        end
        check("t3_no_grant", bad, 0);
        tx_ready = 1'b1;
        step();
        check("t3_grant", src_grant, 4'b0001);

        // Non-granted source traffic is ignored
        do_reset();
        src_req = 4'b0100; tx_ready = 1'b1;
        step();
        check("t4_grant", src_grant, 4'b0100);
        beat(0, 1, 1, 4, 32'hBAD, 1);
        beat(2, 1, 1, 3, 32'hC1, 0);
        step();
        check("t4_fwd", {tx_start, tx_dv, tx_bv, tx_data}, {1'b1, 1'b1, 3'd3, 32'hC1});
        check("t4_hold", src_grant, 4'b0100);
        beat(2, 0, 0, 0, 32'hC1, 0);
        step();
        check("t4_idle", {tx_dv, src_grant}, {1'b0, 4'b0100});
        check("t4_count0", frame_count, 0);
        clear_bus();
        src_done[2] = 1'b1;
        step();
        clear_bus();
        check("t4_count1", frame_count, 1);

        // Reset mid-frame
        do_reset();
        src_req = 4'b0100; tx_ready = 1'b1;
        step();
        beat(2, 1, 1, 4, 32'hD1, 0);
        step();
        beat(2, 0, 1, 4, 32'hD2, 0);
        step();
        check("t5_pre", {tx_dv, tx_data}, {1'b1, 32'hD2});
        #1 rst = 1'b1;
        #1;
        check("t5_async", {src_grant, tx_dv}, {4'b0000, 1'b0});
        clear_bus();
        src_req = 4'b1010;
        step();
        rst = 1'b0;
        step();
        check("t5_lowest", src_grant, 4'b0010);

        // Watchdog
        do_reset();
        src_req = 4'b0110; tx_ready = 1'b1;
        step();
        check("t6_grant", src_grant, 4'b0010);
        w = 0;
        bad = 1'b0;
        while (src_grant == 4'b0010 && w < 40) begin
            if (wd_fault) bad = 1'b1;
            step();
            w++;
        end
`ifdef TX_ARB_WATCHDOG_EN
        check("t6_hold_len", w, 16);
        check("t6_early_fault", bad, 0);
        check("t6_fault", {wd_fault, src_grant}, {1'b1, 4'b0000});
        check("t6_count", frame_count, 0);
        step();
        check("t6_pulse", wd_fault, 0);
        w = 0;
        while (src_grant == 0 && w < 10) begin
            step();
            w++;
        end
        check("t6_next", src_grant, 4'b0100);
`else
        check("t6_hold_len", w, 40);
        check("t6_no_fault", bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ethernet_tx_arbiter.md
Name: ethernet_tx_arbiter

Overview:
- Round-robin scheduler that shares one MAC-facing EthernetTxBus among NUM_PORTS frame sources.
- Sources are crossover/clock-crossing egress blocks, all already in the MAC tx_clk domain.
- Each source raises a request when a complete frame is queued. The arbiter grants one source at a time, forwards that source's bus to the MAC through a registered mux, and enforces an idle gap between frames.

Parameters:
NUM_PORTS, 4, number of requesting sources (2..16)
GAP_CYCLES, 2, idle cycles inserted after src_done before the next grant (>=1)
WATCHDOG_CYCLES, 4096, max cycles a grant may be held (used only with TX_ARB_WATCHDOG_EN)

Ports:
clk  in  1  tx clock; all logic single clock domain
rst  in  1  asynchronous active-high reset
src_req  in  NUM_PORTS  level; source i has a full frame queued
src_grant  out  NUM_PORTS  one-hot level; source i owns the bus
src_done  in  NUM_PORTS  pulse; granted source's frame is complete
src_bus  in  EthernetTxBus[NUM_PORTS]  per-source start/data_valid/bytes_valid/data
tx_ready  in  1  MAC can accept a new frame
tx_bus  out  EthernetTxBus  to MAC
frame_count  out  32  frames completed since reset, wraps
watchdog_fault  out  1  pulse; grant revoked by watchdog (always 0 when the feature is compiled out)

Behaviour:
- Reset (async assert, sync release): state=IDLE, src_grant=0, tx_bus all fields 0, frame_count=0, rr pointer=0, watchdog_fault=0.
- IDLE:
  - If tx_ready and any src_req, pick the first requesting index at or after the rr pointer (wrapping modulo NUM_PORTS).
  - Next cycle: src_grant[sel]=1, rr pointer=(sel+1) mod NUM_PORTS, state=ACTIVE.
  - tx_ready low: no grant, pointer unchanged.
- ACTIVE:
  - tx_bus <= src_bus[sel], one cycle of latency, all fields registered.
  - Non-granted src_bus and src_done are ignored.
  - src_req[sel] deasserting does not revoke the grant.
  - On src_done[sel]: grant drops the next cycle, frame_count increments, state=GAP. A data beat coinciding with src_done is still forwarded.
- GAP:
  - tx_bus start/data_valid/bytes_valid forced 0.
  - A counter runs GAP_CYCLES cycles, then state=IDLE.
  - Requests arriving during GAP are held off and evaluated in IDLE.
- Outside ACTIVE: tx_bus.start/data_valid/bytes_valid are 0 and data holds its last value.
- Grant latency from an idle bus: request + tx_ready in cycle N, grant in cycle N+1. The source's start appears on tx_bus at N+2 at the earliest.
- frame_count wraps from 0xFFFFFFFF to 0 with no flag.
- A single requester is re-granted after every GAP. Fairness: with all ports requesting, grants rotate 0,1,2,...,N-1,0.
- Source contract: a source must not assert start before it sees its grant. A start from a non-granted source is discarded.
- Reset mid-frame: grant and tx_bus clear immediately (async). The in-flight frame is truncated; sources must treat loss of grant as abort.

Optional Feature:
- Macro: TX_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - On reaching WATCHDOG_CYCLES without src_done: grant drops, watchdog_fault pulses for 1 cycle, frame_count does not increment, state=GAP.
  - src_done arriving on the same cycle as expiry wins: normal completion, no fault.
- Undefined: no counter logic; watchdog_fault tied 0; the grant is held indefinitely until src_done.

Test Plan:
- Reset, src_req=4'b0010, tx_ready=1 -> src_grant=4'b0010 one cycle later. Source sends start plus 3 beats (bytes_valid 4,4,2) with src_done on the last beat -> tx_bus shows the same sequence delayed 1 cycle, grant drops, 2 idle cycles, frame_count=1.
- src_req=4'b1111 held, each source sends a 1-beat frame -> grant order 0,1,2,3,0 and frame_count=5.
- src_req=4'b0001 with tx_ready=0 for 10 cycles -> no grant. tx_ready rises at cycle 10 -> grant at cycle 11.
- Port 2 granted; port 0 drives start/data_valid and pulses src_done -> tx_bus shows only port 2 traffic, grant stays on port 2.
- Assert rst mid-frame (beat 2 of 5) -> src_grant=0 and tx_bus.data_valid=0 in the same cycle; after release, first grant goes to the lowest requesting port.
- With TX_ARB_WATCHDOG_EN and WATCHDOG_CYCLES=16, grant port 1 and never send src_done -> grant drops after 16 ACTIVE cycles, watchdog_fault pulses once, frame_count unchanged, next grant goes to port 2 if it is requesting.
